hhmmss_settable_clock: RTL and testbench

Parametrised time-of-day core feeding the 4-digit 7-segment driver. Generalises the fixed hh:mm counter in four ways: it adds seconds, selectable 12/24-hour format, a clock-rate prescaler, and a button-driven set mode. In set mode the field being edited blinks through a per-digit blank mask. Sits between the debounced button pulses and seven_seg_driver in the board top.

---
 rtl/hhmmss_settable_clock_pkg.sv | 25 ++
 rtl/bcd_mod_counter.sv | 76 +++++++
 rtl/hhmmss_settable_clock.sv | 128 ++++++++++++
 tb/tb_hhmmss_settable_clock.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/hhmmss_settable_clock_pkg.sv
// Shared types and limits for the hh:mm:ss time-of-day core and its BCD field counters.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } mode_t;

    typedef logic [3:0] bcd_t;

    localparam int MAX_MIN_SEC = 59;
    localparam int MAX_HOUR_24 = 23;
    // 12h hours are held internally as 0..11, where 0 is shown as "12".
    localparam int MAX_HOUR_12 = 11;

    function automatic mode_t next_mode(input mode_t m);
        case (m)
            RUN:      return SET_HOUR;
            SET_HOUR: return SET_MIN;
            default:  return RUN;
        endcase
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD up/down counter spanning MIN..MAX with wrap in both directions.
// wrap_up is combinational so a carry reaches the next field on the same clock edge.
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter int MIN = 0,
    parameter int MAX = MAX_MIN_SEC
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic dec,
    input  logic load_min,
    output bcd_t ones,
    output bcd_t tens,
    output logic wrap_up
);

    localparam bcd_t MIN_ONES = bcd_t'(MIN % 10);
    localparam bcd_t MIN_TENS = bcd_t'(MIN / 10);
    localparam bcd_t MAX_ONES = bcd_t'(MAX % 10);
    localparam bcd_t MAX_TENS = bcd_t'(MAX / 10);

    bcd_t ones_q, ones_d, tens_q, tens_d;
    logic step_up, step_dn, at_min, at_max;

    // Simultaneous inc and dec cancel; load_min overrides both.
    assign step_up = inc & ~dec & ~load_min;
    assign step_dn = dec & ~inc & ~load_min;
    assign at_min  = (ones_q == MIN_ONES) && (tens_q == MIN_TENS);
    assign at_max  = (ones_q == MAX_ONES) && (tens_q == MAX_TENS);

    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        if (load_min) begin
            ones_d = MIN_ONES;
            tens_d = MIN_TENS;
        end else if (step_up) begin
            if (at_max) begin
                ones_d = MIN_ONES;
                tens_d = MIN_TENS;
            end else if (ones_q == 4'd9) begin
                ones_d = 4'd0;
                tens_d = tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end else if (step_dn) begin
            if (at_min) begin
                ones_d = MAX_ONES;
                tens_d = MAX_TENS;
            end else if (ones_q == 4'd0) begin
                ones_d = 4'd9;
                tens_d = tens_q - 4'd1;
            end else begin
                ones_d = ones_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ones_q <= MIN_ONES;
            tens_q <= MIN_TENS;
        end else begin
            ones_q <= ones_d;
            tens_q <= tens_d;
        end
    end

    assign ones    = ones_q;
    assign tens    = tens_q;
    assign wrap_up = step_up & at_max;

endmodule

// File: rtl/hhmmss_settable_clock.sv
// Settable hh:mm:ss time-of-day core with 12/24h format, blinking edit field and day pulse.
// Buttons are single-cycle pulses with no back-pressure: each is acted on in the cycle it is high.
module hhmmss_settable_clock
    import clock_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BLINK_HZ    = 2,
    parameter int HOUR_24     = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    output bcd_t       sec_ones,
    output bcd_t       sec_tens,
    output bcd_t       min_ones,
    output bcd_t       min_tens,
    output bcd_t       hour_ones,
    output bcd_t       hour_tens,
    output logic       pm,
    output mode_t      mode,
    output logic [3:0] blank,
    output logic       day_clk
);

    localparam int HOUR_MAX   = (HOUR_24 != 0) ? MAX_HOUR_24 : MAX_HOUR_12;
    localparam int PRE_W      = $clog2(CLK_FREQ_HZ + 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_FREQ_HZ - 1);
    localparam int BLINK_RAW  = CLK_FREQ_HZ / (2 * BLINK_HZ);
    localparam int BLINK_HALF = (BLINK_RAW < 1) ? 1 : BLINK_RAW;
    localparam int BLK_W      = $clog2(BLINK_HALF + 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_HALF - 1);

    mode_t             mode_q, mode_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [BLK_W-1:0]  blk_q, blk_d;
    logic              phase_q, phase_d;
    logic              pm_q, pm_d;
    logic              day_q, day_d;

    logic run, edit, sec_tick, leave_run, hr_edit, mn_edit;
    logic sec_wrap, min_wrap, hour_wrap, hour_at_zero, hour_dn_wrap;
    bcd_t hr_ones_raw, hr_tens_raw;
    logic [3:0] blank_c;

    assign run       = (mode_q == RUN);
    assign edit      = ~run & ~btn_mode & (btn_inc ^ btn_dec);
    assign sec_tick  = run & (pre_q == PRE_LAST);
    assign leave_run = run & btn_mode;
    assign hr_edit   = edit & (mode_q == SET_HOUR);
    assign mn_edit   = edit & (mode_q == SET_MIN);

    bcd_mod_counter #(.MIN(0), .MAX(MAX_MIN_SEC)) u_sec (
        .clk(clk), .reset(reset),
        .inc(sec_tick), .dec(1'b0), .load_min(leave_run),
        .ones(sec_ones), .tens(sec_tens), .wrap_up(sec_wrap)
    );

    // Carries are gated with run so a minute edit across 59/00 never moves the hour.
    bcd_mod_counter #(.MIN(0), .MAX(MAX_MIN_SEC)) u_min (
        .clk(clk), .reset(reset),
        .inc((run & sec_wrap) | (mn_edit & btn_inc)), .dec(mn_edit & btn_dec), .load_min(1'b0),
        .ones(min_ones), .tens(min_tens), .wrap_up(min_wrap)
    );

    bcd_mod_counter #(.MIN(0), .MAX(HOUR_MAX)) u_hour (
        .clk(clk), .reset(reset),
        .inc((run & min_wrap) | (hr_edit & btn_inc)), .dec(hr_edit & btn_dec), .load_min(1'b0),
        .ones(hr_ones_raw), .tens(hr_tens_raw), .wrap_up(hour_wrap)
    );

    assign hour_at_zero = (hr_ones_raw == 4'd0) && (hr_tens_raw == 4'd0);
    assign hour_dn_wrap = hr_edit & btn_dec & hour_at_zero;

    always_comb begin
        mode_d  = btn_mode ? next_mode(mode_q) : mode_q;
        pre_d   = (!run || btn_mode || sec_tick) ? '0 : pre_q + 1'b1;
        pm_d    = (HOUR_24 != 0) ? 1'b0 : (pm_q ^ (hour_wrap | hour_dn_wrap));
        day_d   = run & hour_wrap & ((HOUR_24 != 0) || pm_q);
        blk_d   = blk_q + 1'b1;
        phase_d = phase_q;
        // Any mode change or accepted edit restarts the blink with the field visible.
        if (mode_d == RUN || btn_mode || edit) begin
            blk_d   = '0;
            phase_d = 1'b0;
        end else if (blk_q == BLK_LAST) begin
            blk_d   = '0;
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q  <= RUN;
            pre_q   <= '0;
            blk_q   <= '0;
            phase_q <= 1'b0;
            pm_q    <= 1'b0;
            day_q   <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            pre_q   <= pre_d;
            blk_q   <= blk_d;
            phase_q <= phase_d;
            pm_q    <= pm_d;
            day_q   <= day_d;
        end
    end

    assign hour_ones = ((HOUR_24 == 0) && hour_at_zero) ? 4'd2 : hr_ones_raw;
    assign hour_tens = ((HOUR_24 == 0) && hour_at_zero) ? 4'd1 : hr_tens_raw;

    always_comb begin
        blank_c = 4'b0000;
        case (mode_q)
            SET_HOUR: blank_c[3:2] = {2{phase_q}};
            SET_MIN:  blank_c[1:0] = {2{phase_q}};
            default:  blank_c[3]   = (HOUR_24 == 0) && (hour_tens == 4'd0);
        endcase
    end

    assign blank   = blank_c;
    assign pm      = pm_q;
    assign mode    = mode_q;
    assign day_clk = day_q;

endmodule

// File: tb/tb_hhmmss_settable_clock.sv
// Directed bench for hhmmss_settable_clock: a 24h instance (index 0) and a 12h instance (index 1).
module tb_hhmmss_settable_clock;
    import clock_pkg::*;

    typedef struct packed {
        logic [23:0] t;
        logic        pm;
        logic [1:0]  mode;
        logic [3:0]  blank;
        logic        day;
    } obs_t;

    typedef struct {
        string      name;
        logic       m, i, d;
        int         h, mi, s;
        logic [1:0] mode;
        logic [3:0] blank;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst[2], bm[2], bi[2], bd[2];
    logic [3:0] so[2], st[2], mo[2], mt[2], ho[2], ht[2], bl[2];
    logic [1:0] md[2];
    logic pm_w[2], dc[2];
    obs_t obs[2];

    hhmmss_settable_clock #(.CLK_FREQ_HZ(4), .BLINK_HZ(1), .HOUR_24(1)) u24 (
        .clk(clk), .reset(rst[0]), .btn_mode(bm[0]), .btn_inc(bi[0]), .btn_dec(bd[0]),
        .sec_ones(so[0]), .sec_tens(st[0]), .min_ones(mo[0]), .min_tens(mt[0]),
        .hour_ones(ho[0]), .hour_tens(ht[0]), .pm(pm_w[0]), .mode(md[0]),
        .blank(bl[0]), .day_clk(dc[0])
    );

    hhmmss_settable_clock #(.CLK_FREQ_HZ(4), .BLINK_HZ(1), .HOUR_24(0)) u12 (
        .clk(clk), .reset(rst[1]), .btn_mode(bm[1]), .btn_inc(bi[1]), .btn_dec(bd[1]),
        .sec_ones(so[1]), .sec_tens(st[1]), .min_ones(mo[1]), .min_tens(mt[1]),
        .hour_ones(ho[1]), .hour_tens(ht[1]), .pm(pm_w[1]), .mode(md[1]),
        .blank(bl[1]), .day_clk(dc[1])
    );

    assign obs[0] = {ht[0], ho[0], mt[0], mo[0], st[0], so[0], pm_w[0], md[0], bl[0], dc[0]};
    assign obs[1] = {ht[1], ho[1], mt[1], mo[1], st[1], so[1], pm_w[1], md[1], bl[1], dc[1]};

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    vec_t tbl[13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic pulse(input int k, input logic m, input logic i, input logic d);
        bm[k] = m; bi[k] = i; bd[k] = d;
        step();
        bm[k] = 1'b0; bi[k] = 1'b0; bd[k] = 1'b0;
    endtask

    function automatic logic [23:0] hms(input int h, input int m, input int s);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic check(input string name, input int k, input obs_t exp);
        n_vec++;
        if (obs[k] !== exp) begin
            n_err++;
            $display("FAIL %s: got t=%h pm=%b mode=%0d blank=%b day=%b, expected t=%h pm=%b mode=%0d blank=%b day=%b",
                     name, obs[k].t, obs[k].pm, obs[k].mode, obs[k].blank, obs[k].day,
                     exp.t, exp.pm, exp.mode, exp.blank, exp.day);
        end
    endtask

    task automatic chk(input string name, input int k, input int h, input int m, input int s,
                       input logic p, input logic [1:0] mode, input logic [3:0] blank, input logic day);
        obs_t e;
        e = '{t: hms(h, m, s), pm: p, mode: mode, blank: blank, day: day};
        check(name, k, e);
    endtask

    initial begin
        int day_cnt;
        obs_t e;
        // name, mode, inc, dec, hh, mm, ss, mode, blank  (24h instance)
        tbl[0]  = '{"enter_set_hour",  1'b1, 1'b0, 1'b0,  0,  0, 0, 2'd1, 4'b0000};
        tbl[1]  = '{"inc_dec_same",    1'b0, 1'b1, 1'b1,  0,  0, 0, 2'd1, 4'b0000};
        tbl[2]  = '{"hour_dec_wrap",   1'b0, 1'b0, 1'b1, 23,  0, 0, 2'd1, 4'b0000};
        tbl[3]  = '{"mode_beats_inc",  1'b1, 1'b1, 1'b0, 23,  0, 0, 2'd2, 4'b0000};
        tbl[4]  = '{"blink_vis_1",     1'b0, 1'b0, 1'b0, 23,  0, 0, 2'd2, 4'b0000};
        tbl[5]  = '{"blink_dark_0",    1'b0, 1'b0, 1'b0, 23,  0, 0, 2'd2, 4'b0011};
        tbl[6]  = '{"blink_dark_1",    1'b0, 1'b0, 1'b0, 23,  0, 0, 2'd2, 4'b0011};
        tbl[7]  = '{"min_dec_wrap",    1'b0, 1'b0, 1'b1, 23, 59, 0, 2'd2, 4'b0000};
        tbl[8]  = '{"edit_vis_1",      1'b0, 1'b0, 1'b0, 23, 59, 0, 2'd2, 4'b0000};
        tbl[9]  = '{"edit_dark",       1'b0, 1'b0, 1'b0, 23, 59, 0, 2'd2, 4'b0011};
        tbl[10] = '{"min_inc_wrap",    1'b0, 1'b1, 1'b0, 23,  0, 0, 2'd2, 4'b0000};
        tbl[11] = '{"min_back_59",     1'b0, 1'b0, 1'b1, 23, 59, 0, 2'd2, 4'b0000};
        tbl[12] = '{"back_to_run",     1'b1, 1'b0, 1'b0, 23, 59, 0, 2'd0, 4'b0000};

        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; bm[k] = 1'b0; bi[k] = 1'b0; bd[k] = 1'b0;
        end
        idle(2);
        chk("reset_24", 0, 0, 0, 0, 1'b0, 2'd0, 4'b0000, 1'b0);
        chk("reset_12", 1, 12, 0, 0, 1'b0, 2'd0, 4'b0000, 1'b0);

        rst[0] = 1'b0; rst[1] = 1'b0;
        day_cnt = 0;
        repeat (240) begin
            step();
            if (dc[0]) day_cnt++;
        end
        chk("run_240_24", 0, 0, 1, 0, 1'b0, 2'd0, 4'b0000, 1'b0);
        chk("run_240_12", 1, 12, 1, 0, 1'b0, 2'd0, 4'b0000, 1'b0);
        n_vec++;
        if (day_cnt != 0) begin
            n_err++;
            $display("FAIL no_day_in_240: day_clk pulses=%0d expected 0", day_cnt);
        end

        idle(2);
        rst[0] = 1'b1; step();
        chk("mid_count_reset", 0, 0, 0, 0, 1'b0, 2'd0, 4'b0000, 1'b0);
        rst[0] = 1'b0;
        pulse(0, 1'b1, 1'b0, 1'b0);
        chk("edit_enter", 0, 0, 0, 0, 1'b0, 2'd1, 4'b0000, 1'b0);
        pulse(0, 1'b0, 1'b1, 1'b0);
        chk("hour_inc", 0, 1, 0, 0, 1'b0, 2'd1, 4'b0000, 1'b0);
        rst[0] = 1'b1; step();
        chk("mid_edit_reset", 0, 0, 0, 0, 1'b0, 2'd0, 4'b0000, 1'b0);
        rst[0] = 1'b0;
        idle(6);
        chk("first_second", 0, 0, 0, 1, 1'b0, 2'd0, 4'b0000, 1'b0);

        foreach (tbl[n]) exp_q.push_back({hms(tbl[n].h, tbl[n].mi, tbl[n].s), 1'b0, tbl[n].mode, tbl[n].blank, 1'b0});
        for (int n = 0; n < 13; n++) begin
            pulse(0, tbl[n].m, tbl[n].i, tbl[n].d);
            e = exp_q.pop_front();
            check(tbl[n].name, 0, e);
        end

        idle(3);
        chk("no_tick_yet", 0, 23, 59, 0, 1'b0, 2'd0, 4'b0000, 1'b0);
        step();
        chk("first_tick_4", 0, 23, 59, 1, 1'b0, 2'd0, 4'b0000, 1'b0);
        pulse(0, 1'b0, 1'b1, 1'b0);
        chk("inc_in_run", 0, 23, 59, 1, 1'b0, 2'd0, 4'b0000, 1'b0);
        idle(231);
        chk("at_235959", 0, 23, 59, 59, 1'b0, 2'd0, 4'b0000, 1'b0);
        idle(3);
        chk("hold_235959", 0, 23, 59, 59, 1'b0, 2'd0, 4'b0000, 1'b0);
        step();
        chk("day_roll_24", 0, 0, 0, 0, 1'b0, 2'd0, 4'b0000, 1'b1);
        step();
        chk("day_one_cycle", 0, 0, 0, 0, 1'b0, 2'd0, 4'b0000, 1'b0);

        rst[1] = 1'b1; step(); rst[1] = 1'b0;
        pulse(1, 1'b1, 1'b0, 1'b0);
        chk("12h_set_hour", 1, 12, 0, 0, 1'b0, 2'd1, 4'b0000, 1'b0);
        pulse(1, 1'b0, 1'b0, 1'b1);
        chk("12h_dec_12_11", 1, 11, 0, 0, 1'b1, 2'd1, 4'b0000, 1'b0);
        pulse(1, 1'b0, 1'b1, 1'b0);
        chk("12h_inc_11_12", 1, 12, 0, 0, 1'b0, 2'd1, 4'b0000, 1'b0);
        repeat (11) pulse(1, 1'b0, 1'b1, 1'b0);
        chk("12h_inc_to_11am", 1, 11, 0, 0, 1'b0, 2'd1, 4'b0000, 1'b0);
        pulse(1, 1'b1, 1'b0, 1'b0);
        pulse(1, 1'b0, 1'b0, 1'b1);
        pulse(1, 1'b1, 1'b0, 1'b0);
        chk("12h_run_1159am", 1, 11, 59, 0, 1'b0, 2'd0, 4'b0000, 1'b0);
        idle(236);
        chk("12h_115959am", 1, 11, 59, 59, 1'b0, 2'd0, 4'b0000, 1'b0);
        idle(4);
        chk("12h_noon", 1, 12, 0, 0, 1'b1, 2'd0, 4'b0000, 1'b0);

        pulse(1, 1'b1, 1'b0, 1'b0);
        repeat (11) pulse(1, 1'b0, 1'b1, 1'b0);
        chk("12h_inc_to_11pm", 1, 11, 0, 0, 1'b1, 2'd1, 4'b0000, 1'b0);
        pulse(1, 1'b1, 1'b0, 1'b0);
        pulse(1, 1'b0, 1'b0, 1'b1);
        pulse(1, 1'b1, 1'b0, 1'b0);
        idle(236);
        chk("12h_115959pm", 1, 11, 59, 59, 1'b1, 2'd0, 4'b0000, 1'b0);
        idle(4);
        chk("12h_midnight", 1, 12, 0, 0, 1'b0, 2'd0, 4'b0000, 1'b1);
        step();
        chk("12h_day_one_cycle", 1, 12, 0, 0, 1'b0, 2'd0, 4'b0000, 1'b0);

        pulse(1, 1'b1, 1'b0, 1'b0);
        repeat (9) pulse(1, 1'b0, 1'b1, 1'b0);
        pulse(1, 1'b1, 1'b0, 1'b0);
        pulse(1, 1'b1, 1'b0, 1'b0);
        chk("12h_lead_zero", 1, 9, 0, 0, 1'b0, 2'd0, 4'b1000, 1'b0);
        pulse(1, 1'b1, 1'b0, 1'b0);
        pulse(1, 1'b0, 1'b1, 1'b0);
        pulse(1, 1'b1, 1'b0, 1'b0);
        pulse(1, 1'b1, 1'b0, 1'b0);
        chk("12h_no_lead_zero", 1, 10, 0, 0, 1'b0, 2'd0, 4'b0000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
